acc_reg_file_ras: RTL and testbench
===================================

ACC_REG_FILE_RAS -- requirements
Module: acc_reg_file_ras

Interface
REQ-001 Parameter DW, default 8, data width of every general register and the accumulator.
REQ-002 Parameter NREG, default 16, number of registers; register 0 is the accumulator; AW = clog2(NREG).
REQ-003 Parameter TW, default 10, branch-target width.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; at least 2.
REQ-005 Parameter BYPASS, default 0; 1 = write-through read forwarding.
REQ-006 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 WriteR0  input  1  write DataIn to the accumulator (R0).
REQ-009 GenRegWrite  input  1  write DataIn to register Raddr.
REQ-010 Raddr  input  AW  operand read index, also the general write index.
REQ-011 DataIn  input  DW  write data.
REQ-012 LUTsignal  input  1  load Target into the branch register.
REQ-013 Target  input  TW  branch target from the LUT.
REQ-014 Push  input  1  push PushAddr onto the return-address stack.
REQ-015 PushAddr  input  TW  return address to push.
REQ-016 Pop  input  1  pop the stack top into the branch register.
REQ-017 DataOutOperand  output  DW  reg[Raddr], combinational.
REQ-018 DataOutAccumulator  output  DW  reg[0], combinational.
REQ-019 DataOutBranchReg  output  TW  branch register.
REQ-020 RasFull, RasEmpty  output  1 each  stack occupancy flags.
REQ-021 RasOverflow, RasUnderflow  output  1 each  sticky error flags.

Function
REQ-022 WriteR0 shall write DataIn to reg[0]; GenRegWrite shall write DataIn to reg[Raddr]; Raddr=0 with both asserted shall produce a single write of DataIn.
REQ-023 Reads shall be combinational; with BYPASS=0 they return the pre-edge value; with BYPASS=1 a read of a register being written this cycle shall return DataIn.
REQ-024 LUTsignal shall load Target into the branch register at the next edge.
REQ-025 Stack: pointer-based, count 0..RAS_DEPTH; RasEmpty = (count==0); RasFull = (count==RAS_DEPTH).
REQ-026 Push alone, not full: store PushAddr at the top, count+1; Push when full: dropped, count unchanged, RasOverflow set.
REQ-027 Pop alone, not empty: branch register <= top entry, count-1; Pop when empty: no state change except RasUnderflow set.
REQ-028 Push and Pop together, not empty: branch register <= old top, top replaced by PushAddr, count unchanged; when empty: push proceeds, RasUnderflow set.
REQ-029 Pop and LUTsignal together: Pop wins for the branch register (only when the pop is valid); an invalid pop leaves LUTsignal effective.
REQ-030 Sticky flags shall clear only on Reset.
REQ-031 Latency: every write, push or pop is visible on the outputs one edge after the request.

Reset
REQ-032 Reset shall zero all registers, the branch register, the stack pointer/count and both sticky flags; RasEmpty=1, RasFull=0.
REQ-033 Reset shall dominate every other input in the same cycle, including mid-sequence pushes.
REQ-034 Stack entry storage need not be cleared; its contents shall be unobservable while empty.

Structure
REQ-035 A shared package shall hold the default parameter values and the stack-operation enum {NONE, PUSH, POP, SWAP}.
REQ-036 The return-address stack shall be one sub-module, ras_stack, containing the storage, count, flags and stack-operation decode.

Verification
REQ-037 Reset, DataIn=13, WriteR0 pulse -> DataOutAccumulator=13, all other registers 0.
REQ-038 Raddr=5, DataIn=0x5A, GenRegWrite -> DataOutOperand=0x5A next cycle; BYPASS=1 shows 0x5A in the same cycle.
REQ-039 Target=255, LUTsignal -> DataOutBranchReg=255.
REQ-040 Push 0x101..0x104 (depth 4), then push 0x105 -> RasFull=1, RasOverflow=1; four pops -> branch 0x104,0x103,0x102,0x101 in turn, RasEmpty=1.
REQ-041 Pop when empty -> RasUnderflow=1, branch register unchanged; Push 0x0AA with Pop on count 1 (top 0x011) -> branch=0x011, top=0x0AA, count 1.
REQ-042 Reset asserted mid push sequence -> next cycle count 0, flags clear, registers 0.

Source files
------------

// File: rtl/acc_reg_file_ras_pkg.sv
// Shared definitions for the accumulator register file and its return-address stack.
package acc_reg_file_ras_pkg;

    // Default parameter values shared by the top and the stack sub-module.
    localparam int unsigned DEF_DW        = 8;
    localparam int unsigned DEF_NREG      = 16;
    localparam int unsigned DEF_TW        = 10;
    localparam int unsigned DEF_RAS_DEPTH = 4;
    localparam int unsigned DEF_BYPASS    = 0;

    // Stack operation requested in a cycle, decoded from the push/pop pair.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        PUSH = 2'b01,
        POP  = 2'b10,
        SWAP = 2'b11
    } ras_op_e;

endpackage

// File: rtl/acc_reg_file_ras_ras_stack.sv
// Return-address stack: entry storage, occupancy count, flags and op decode.
// Storage is not reset; the top output is forced to zero while empty so stale
// entries can never be observed.
module ras_stack
    import acc_reg_file_ras_pkg::*;
#(
    parameter int unsigned TW    = DEF_TW,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [TW-1:0] push_addr,
    output logic [TW-1:0] top,
    output logic          pop_valid,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [TW-1:0] mem [DEPTH];
    logic [CW-1:0] count;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] mem_idx;
    logic          mem_we;
    ras_op_e       op;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign top_idx   = PW'(count - CW'(1));
    assign top       = empty ? '0 : mem[top_idx];
    assign pop_valid = pop && !empty;

    // Decode the push/pop request pair into a single stack operation.
    always_comb begin
        op = NONE;
        unique case ({push, pop})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = SWAP;
            default: op = NONE;
        endcase
    end

    // Pick the storage slot written this cycle; a swap on an empty stack
    // degenerates into a plain push into slot 0.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = '0;
        unique case (op)
            PUSH: begin
                mem_we  = !full;
                mem_idx = PW'(count);
            end
            SWAP: begin
                mem_we  = 1'b1;
                mem_idx = empty ? '0 : top_idx;
            end
            default: begin
                mem_we  = 1'b0;
                mem_idx = '0;
            end
        endcase
    end

    // Entry storage update; suppressed during reset so reset dominates pushes.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_idx] <= push_addr;
        end
    end

    // Occupancy count and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            unique case (op)
                PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                SWAP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                        count     <= CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/acc_reg_file_ras.sv
// Accumulator/general register file with a branch register fed either by the
// LUT target or by the return-address stack.
module acc_reg_file_ras
    import acc_reg_file_ras_pkg::*;
#(
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned NREG      = DEF_NREG,
    parameter int unsigned TW        = DEF_TW,
    parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH,
    parameter int unsigned BYPASS    = DEF_BYPASS,
    localparam int unsigned AW       = $clog2(NREG)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WriteR0,
    input  logic          GenRegWrite,
    input  logic [AW-1:0] Raddr,
    input  logic [DW-1:0] DataIn,
    input  logic          LUTsignal,
    input  logic [TW-1:0] Target,
    input  logic          Push,
    input  logic [TW-1:0] PushAddr,
    input  logic          Pop,
    output logic [DW-1:0] DataOutOperand,
    output logic [DW-1:0] DataOutAccumulator,
    output logic [TW-1:0] DataOutBranchReg,
    output logic          RasFull,
    output logic          RasEmpty,
    output logic          RasOverflow,
    output logic          RasUnderflow
);

    logic [DW-1:0] regs [NREG];
    logic [TW-1:0] branch_reg;
    logic [TW-1:0] ras_top;
    logic          ras_pop_valid;
    logic          hit_operand;
    logic          hit_acc;

    ras_stack #(
        .TW    (TW),
        .DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clk       (Clk),
        .reset     (Reset),
        .push      (Push),
        .pop       (Pop),
        .push_addr (PushAddr),
        .top       (ras_top),
        .pop_valid (ras_pop_valid),
        .full      (RasFull),
        .empty     (RasEmpty),
        .overflow  (RasOverflow),
        .underflow (RasUnderflow)
    );

    // Register writes; WriteR0 and GenRegWrite to R0 carry the same data, so
    // both landing on R0 is a single write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (GenRegWrite) begin
                regs[Raddr] <= DataIn;
            end
            if (WriteR0) begin
                regs[0] <= DataIn;
            end
        end
    end

    // Branch register: a valid pop has priority over the LUT target.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            branch_reg <= '0;
        end else if (ras_pop_valid) begin
            branch_reg <= ras_top;
        end else if (LUTsignal) begin
            branch_reg <= Target;
        end
    end

    // Combinational reads with optional write-through forwarding.
    always_comb begin
        hit_operand        = GenRegWrite || (WriteR0 && (Raddr == '0));
        hit_acc            = WriteR0 || (GenRegWrite && (Raddr == '0));
        DataOutOperand     = regs[Raddr];
        DataOutAccumulator = regs[0];
        if (BYPASS != 0) begin
            if (hit_operand) begin
                DataOutOperand = DataIn;
            end
            if (hit_acc) begin
                DataOutAccumulator = DataIn;
            end
        end
    end

    assign DataOutBranchReg = branch_reg;

endmodule

// File: tb/tb_acc_reg_file_ras.sv
// Directed bench for acc_reg_file_ras: one plain instance and one with
// write-through forwarding, both driven by the same stimulus.
module tb_acc_reg_file_ras;

    localparam int unsigned DW = 8;
    localparam int unsigned TW = 10;
    localparam int unsigned AW = 4;

    logic          Clk;
    logic          Reset;
    logic          WriteR0;
    logic          GenRegWrite;
    logic [AW-1:0] Raddr;
    logic [DW-1:0] DataIn;
    logic          LUTsignal;
    logic [TW-1:0] Target;
    logic          Push;
    logic [TW-1:0] PushAddr;
    logic          Pop;

    logic [DW-1:0] op0, acc0;
    logic [TW-1:0] br0;
    logic          full0, empty0, ovf0, udf0;
    logic [DW-1:0] op1, acc1;
    logic [TW-1:0] br1;
    logic          full1, empty1, ovf1, udf1;

    int errors = 0;
    int checks = 0;

    acc_reg_file_ras #(
        .DW(DW), .NREG(16), .TW(TW), .RAS_DEPTH(4), .BYPASS(0)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .WriteR0(WriteR0), .GenRegWrite(GenRegWrite),
        .Raddr(Raddr), .DataIn(DataIn), .LUTsignal(LUTsignal), .Target(Target),
        .Push(Push), .PushAddr(PushAddr), .Pop(Pop),
        .DataOutOperand(op0), .DataOutAccumulator(acc0), .DataOutBranchReg(br0),
        .RasFull(full0), .RasEmpty(empty0), .RasOverflow(ovf0), .RasUnderflow(udf0)
    );

    acc_reg_file_ras #(
        .DW(DW), .NREG(16), .TW(TW), .RAS_DEPTH(4), .BYPASS(1)
    ) u_byp (
        .Clk(Clk), .Reset(Reset), .WriteR0(WriteR0), .GenRegWrite(GenRegWrite),
        .Raddr(Raddr), .DataIn(DataIn), .LUTsignal(LUTsignal), .Target(Target),
        .Push(Push), .PushAddr(PushAddr), .Pop(Pop),
        .DataOutOperand(op1), .DataOutAccumulator(acc1), .DataOutBranchReg(br1),
        .RasFull(full1), .RasEmpty(empty1), .RasOverflow(ovf1), .RasUnderflow(udf1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset = 0; WriteR0 = 0; GenRegWrite = 0; LUTsignal = 0; Push = 0; Pop = 0;
    endtask

    task automatic chk_flags(input string tag, input logic f, input logic e,
                             input logic o, input logic u);
        chk({tag, ".full"},  32'(full0),  32'(f));
        chk({tag, ".empty"}, 32'(empty0), 32'(e));
        chk({tag, ".ovf"},   32'(ovf0),   32'(o));
        chk({tag, ".udf"},   32'(udf0),   32'(u));
    endtask

    initial begin
        idle();
        Raddr = '0; DataIn = '0; Target = '0; PushAddr = '0;
        #2;

        // Reset state
        Reset = 1; tick(); idle();
        chk("rst.acc", 32'(acc0), 32'h0);
        chk("rst.branch", 32'(br0), 32'h0);
        chk_flags("rst", 0, 1, 0, 0);

        // WriteR0 of 13; all other registers stay zero
        DataIn = 8'd13; WriteR0 = 1; tick(); idle();
        chk("wr0.acc", 32'(acc0), 32'd13);
        for (int i = 1; i < 16; i++) begin
            Raddr = AW'(i); #1;
            chk($sformatf("wr0.reg%0d", i), 32'(op0), 32'h0);
        end

        // General write to R5, with and without forwarding
        Raddr = 4'd5; DataIn = 8'h5A; GenRegWrite = 1; #1;
        chk("gen.pre_nobyp", 32'(op0), 32'h0);
        chk("gen.pre_byp", 32'(op1), 32'h5A);
        tick(); idle();
        chk("gen.post_nobyp", 32'(op0), 32'h5A);
        chk("gen.acc_kept", 32'(acc0), 32'd13);

        // Both write enables targeting R0
        Raddr = 4'd0; DataIn = 8'h77; WriteR0 = 1; GenRegWrite = 1; #1;
        chk("dual.pre_nobyp", 32'(acc0), 32'd13);
        chk("dual.pre_byp_acc", 32'(acc1), 32'h77);
        chk("dual.pre_byp_op", 32'(op1), 32'h77);
        tick(); idle();
        chk("dual.acc", 32'(acc0), 32'h77);
        Raddr = 4'd5; #1;
        chk("dual.r5_kept", 32'(op0), 32'h5A);

        // LUT load
        Target = 10'd255; LUTsignal = 1; tick(); idle();
        chk("lut.branch", 32'(br0), 32'd255);

        // Fill the stack, then overflow it
        for (int i = 1; i <= 4; i++) begin
            PushAddr = TW'(32'h100 + i); Push = 1; tick(); idle();
        end
        chk_flags("fill", 1, 0, 0, 0);
        chk("fill.branch", 32'(br0), 32'd255);
        PushAddr = 10'h105; Push = 1; tick(); idle();
        chk_flags("ovf", 1, 0, 1, 0);

        // Drain: overflowed push must not have been stored
        for (int i = 4; i >= 1; i--) begin
            Pop = 1; tick(); idle();
            chk($sformatf("pop%0d.branch", i), 32'(br0), 32'h100 + 32'(i));
        end
        chk_flags("drained", 0, 1, 1, 0);

        // Pop on empty: underflow, branch unchanged
        Pop = 1; tick(); idle();
        chk("udf.branch", 32'(br0), 32'h101);
        chk_flags("udf", 0, 1, 1, 1);

        // Invalid pop with LUT: LUT still loads
        Pop = 1; LUTsignal = 1; Target = 10'h033; tick(); idle();
        chk("udf_lut.branch", 32'(br0), 32'h033);

        // Swap on count 1
        PushAddr = 10'h011; Push = 1; tick(); idle();
        PushAddr = 10'h0AA; Push = 1; Pop = 1; tick(); idle();
        chk("swap.branch", 32'(br0), 32'h011);
        chk_flags("swap", 0, 0, 1, 1);
        Pop = 1; tick(); idle();
        chk("swap.top", 32'(br0), 32'h0AA);
        chk("swap.empty_after", 32'(empty0), 32'h1);

        // Valid pop beats LUT
        PushAddr = 10'h022; Push = 1; tick(); idle();
        Pop = 1; LUTsignal = 1; Target = 10'h3FF; tick(); idle();
        chk("pop_lut.branch", 32'(br0), 32'h022);

        // Reset in the middle of a push sequence, with a write also requested
        PushAddr = 10'h001; Push = 1; tick(); idle();
        PushAddr = 10'h002; Push = 1; tick(); idle();
        PushAddr = 10'h003; Push = 1; WriteR0 = 1; DataIn = 8'hEE; Reset = 1;
        tick(); idle();
        chk_flags("midrst", 0, 1, 0, 0);
        chk("midrst.acc", 32'(acc0), 32'h0);
        chk("midrst.branch", 32'(br0), 32'h0);
        Raddr = 4'd5; #1;
        chk("midrst.r5", 32'(op0), 32'h0);
        chk("midrst.byp_empty", 32'(empty1), 32'h1);

        // Swap on empty: push proceeds, underflow raised
        PushAddr = 10'h0BB; Push = 1; Pop = 1; tick(); idle();
        chk_flags("swap_empty", 0, 0, 0, 1);
        chk("swap_empty.branch", 32'(br0), 32'h0);
        Pop = 1; tick(); idle();
        chk("swap_empty.pop", 32'(br0), 32'h0BB);
        chk_flags("swap_empty.after", 0, 1, 0, 1);
        chk("byp.branch", 32'(br1), 32'h0BB);
        chk("byp.udf", 32'(udf1), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
